// File: rtl/ercd_pkg.sv
// ----------------------------------------------------------------------------
// ercd_pkg
// Shared definitions for the ercd16_8 sequential 16/8 restoring divider.
//   - state_e   : controller states (IDLE, CALC, DONE)
//   - DIVIDEND_W, DIVISOR_W, QUO_W : fixed datapath geometry
//   - ERR_QUO   : quotient reported on divide-by-zero / quotient overflow
// ----------------------------------------------------------------------------
package ercd_pkg;

  localparam int DIVIDEND_W = 16;
  localparam int DIVISOR_W  = 8;
  localparam int QUO_W      = 8;
  localparam int CNT_W      = 3;

  localparam logic [QUO_W-1:0] ERR_QUO = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage : ercd_pkg

// File: rtl/ercd_step.sv
// ----------------------------------------------------------------------------
// ercd_step
// One combinational restoring-division step.
//   rem_in  [7:0] : current partial remainder R (always < divisor)
//   bit_in        : next dividend bit shifted into R
//   divisor [7:0] : divisor
//   rem_out [7:0] : new partial remainder
//   q_bit         : quotient bit produced by this step
// ----------------------------------------------------------------------------
module ercd_step
  import ercd_pkg::*;
(
  input  logic [DIVISOR_W-1:0] rem_in,
  input  logic                 bit_in,
  input  logic [DIVISOR_W-1:0] divisor,
  output logic [DIVISOR_W-1:0] rem_out,
  output logic                 q_bit
);

  // Trial value needs one extra bit: R < divisor, so {R, bit} < 2*divisor.
  logic [DIVISOR_W:0] trial;

  assign trial = {rem_in, bit_in};
  assign q_bit = (trial >= {1'b0, divisor});

  // When the subtraction succeeds the result is < divisor, so it fits in the
  // low 8 bits and the carry out of bit 8 can be dropped.
  assign rem_out = q_bit ? (trial[DIVISOR_W-1:0] - divisor) : trial[DIVISOR_W-1:0];

endmodule : ercd_step

// File: rtl/ercd16_8.sv
// ----------------------------------------------------------------------------
// ercd16_8
// Sequential unsigned 16/8 restoring divider with valid/ready handshakes.
// One quotient bit per cycle; 8 CALC cycles per normal division. Divide by
// zero, or a quotient that would not fit in 8 bits, returns quo_o = 8'hFF,
// rem_o = 0, err_o = 1 one cycle after acceptance.
//
// Optional build macro: ERCD16_8_MASK_EN
//   defined   -> quo_o = {q[7], q[6:0] & mask latched at acceptance}
//   undefined -> mask is ignored, quotient is exact
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   in_valid   in   request valid
//   in_ready   out  high only in IDLE
//   dat_in_a   in   [15:0] unsigned dividend
//   dat_in_b   in   [7:0]  unsigned divisor
//   mask       in   [6:0]  quotient low-bit enables (MASK_EN builds only)
//   out_valid  out  result valid
//   out_ready  in   result accepted
//   quo_o      out  [7:0] quotient
//   rem_o      out  [7:0] remainder
//   err_o      out  divide-by-zero or quotient overflow
// ----------------------------------------------------------------------------
module ercd16_8
  import ercd_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] dat_in_a,
  input  logic [DIVISOR_W-1:0]  dat_in_b,
  input  logic [QUO_W-2:0]      mask,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [QUO_W-1:0]      quo_o,
  output logic [DIVISOR_W-1:0]  rem_o,
  output logic                  err_o
);

  localparam logic [1:0] IDLE = ST_IDLE;
  localparam logic [1:0] CALC = ST_CALC;
  localparam logic [1:0] DONE = ST_DONE;

  logic [1:0]           state;
  logic [DIVISOR_W-1:0] rem_q;     // partial remainder R
  logic [7:0]           shf_q;     // remaining dividend low bits S
  logic [DIVISOR_W-1:0] div_q;     // latched divisor
  logic [QUO_W-2:0]     quo_acc;   // quotient bits produced so far, MSB first
  logic [CNT_W-1:0]     cnt;

  logic [DIVISOR_W-1:0] step_rem;
  logic                 step_q;
  logic [QUO_W-1:0]     quo_full;
  logic [QUO_W-1:0]     quo_final;
  logic                 req_err;

  assign in_ready = (state == IDLE);

  assign req_err = (dat_in_b == '0) || (dat_in_a[15:8] >= dat_in_b);

  ercd_step u_step (
    .rem_in  (rem_q),
    .bit_in  (shf_q[7]),
    .divisor (div_q),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  // On the last step the accumulator holds q[7:1] and the step supplies q[0].
  assign quo_full = {quo_acc, step_q};

`ifdef ERCD16_8_MASK_EN
  logic [QUO_W-2:0] mask_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask_q <= '0;
    end else if (in_valid && in_ready) begin
      mask_q <= mask;
    end
  end

  assign quo_final = {quo_full[QUO_W-1], quo_full[QUO_W-2:0] & mask_q};
`else
  // The mask input has no function in this build.
  logic unused_mask;
  assign unused_mask = ^mask;
  assign quo_final   = quo_full;
`endif

  // NOTE: every register below is updated with non-blocking assignments so
  // all state moves together on the edge and the order of statements inside
  // the block cannot change the result.
  // NOTE: these are a handful of control/datapath flops, so all of them take
  // the asynchronous reset; a reset mid-division discards the work in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rem_q     <= '0;
      shf_q     <= '0;
      div_q     <= '0;
      quo_acc   <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      quo_o     <= '0;
      rem_o     <= '0;
      err_o     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            div_q <= dat_in_b;
            if (req_err) begin
              // Error result is published on the following edge (DONE with
              // out_valid still low marks a pending error response).
              state <= DONE;
            end else begin
              rem_q <= dat_in_a[15:8];
              shf_q <= dat_in_a[7:0];
              cnt   <= CNT_W'(QUO_W - 1);
              state <= CALC;
            end
          end
        end

        CALC: begin
          rem_q   <= step_rem;
          shf_q   <= {shf_q[6:0], 1'b0};
          quo_acc <= {quo_acc[QUO_W-3:0], step_q};
          if (cnt == '0) begin
            quo_o     <= quo_final;
            rem_o     <= step_rem;
            err_o     <= 1'b0;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        DONE: begin
          if (!out_valid) begin
            quo_o     <= ERR_QUO;
            rem_o     <= '0;
            err_o     <= 1'b1;
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end

        default: begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule : ercd16_8

// File: tb/tb_ercd16_8.sv
// ----------------------------------------------------------------------------
// tb_ercd16_8
// Self-checking bench for ercd16_8. Expected results come from plain integer
// division (a / b, a % b) with the error and mask rules applied on top.
// Honours ERCD16_8_MASK_EN the same way the design does.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ercd16_8;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] dat_in_a;
  logic [7:0]  dat_in_b;
  logic [6:0]  mask;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  quo_o;
  logic [7:0]  rem_o;
  logic        err_o;

  int checks   = 0;
  int failures = 0;

  ercd16_8 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dat_in_a  (dat_in_a),
    .dat_in_b  (dat_in_b),
    .mask      (mask),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quo_o     (quo_o),
    .rem_o     (rem_o),
    .err_o     (err_o)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached (checks=%0d)", checks);
    $fatal(1, "watchdog");
  end

  // Reference model: integer division plus the error and mask rules.
  function automatic void model(input logic [15:0] a, input logic [7:0] b,
                                input logic [6:0] m, output logic [7:0] q,
                                output logic [7:0] r, output logic e);
    int unsigned qi;
    int unsigned ri;
    logic [6:0]  m_eff;
`ifdef ERCD16_8_MASK_EN
    m_eff = m;
`else
    m_eff = 7'h7F & (m | 7'h7F);
`endif
    if (b == 8'd0) begin
      q = 8'hFF; r = 8'h00; e = 1'b1;
      return;
    end
    qi = int'(a) / int'(b);
    ri = int'(a) % int'(b);
    if (qi > 255) begin
      q = 8'hFF; r = 8'h00; e = 1'b1;
    end else begin
      q = qi[7:0] & {1'b1, m_eff};
      r = ri[7:0];
      e = 1'b0;
    end
  endfunction

  // Present a request and wait for its acceptance edge; leaves time at
  // accept edge + 1 with in_valid dropped and operands scrambled.
  task automatic send(input logic [15:0] a, input logic [7:0] b,
                      input logic [6:0] m, output bit ok);
    int n;
    ok = 1'b0;
    n  = 0;
    while (!ok && n < 40) begin
      @(negedge clk);
      ok = in_ready;
      n++;
    end
    if (!ok) return;
    in_valid = 1'b1;
    dat_in_a = a;
    dat_in_b = b;
    mask     = m;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    dat_in_a = 16'($urandom);
    dat_in_b = 8'($urandom);
    mask     = 7'($urandom);
  endtask

  // Count edges after acceptance until out_valid is seen.
  task automatic wait_out(output int lat, output bit ok);
    lat = 0;
    ok  = out_valid;
    while (!ok && lat < 30) begin
      @(posedge clk);
      #1;
      lat++;
      ok = out_valid;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic run_one(input logic [15:0] a, input logic [7:0] b, input logic [6:0] m,
                         output logic [7:0] q, output logic [7:0] r, output logic e,
                         output int lat, output bit ok);
    bit acc_ok;
    send(a, b, m, acc_ok);
    lat = 0;
    ok  = acc_ok;
    q = 'x; r = 'x; e = 'x;
    if (!acc_ok) return;
    wait_out(lat, ok);
    if (!ok) return;
    q = quo_o; r = rem_o; e = err_o;
    consume();
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    dat_in_a = '0; dat_in_b = '0; mask = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    checks++; if (quo_o !== 8'h00) begin failures++; $display("FAIL reset_quo got=%h want=00", quo_o); end
    checks++; if (rem_o !== 8'h00) begin failures++; $display("FAIL reset_rem got=%h want=00", rem_o); end
    checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL reset_err got=%b want=0", err_o); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Directed vectors: basic, divide-by-zero, overflow, max in-range.
  task automatic test_directed();
    logic [15:0] va [5] = '{16'h1234, 16'h00FF, 16'h5600, 16'hFE01, 16'h00FF};
    logic [7:0]  vb [5] = '{8'h56,    8'h00,    8'h56,    8'hFF,    8'h01};
    logic [7:0]  q, r, eq, er;
    logic        e, ee;
    int          lat, elat;
    bit          ok;
    for (int i = 0; i < 5; i++) begin
      model(va[i], vb[i], 7'h7F, eq, er, ee);
      elat = ee ? 1 : 8;
      run_one(va[i], vb[i], 7'h7F, q, r, e, lat, ok);
      checks++;
      if (!ok) begin
        failures++; $display("FAIL dir%0d_timeout no result for %h/%h", i, va[i], vb[i]);
      end else if (q !== eq || r !== er || e !== ee) begin
        failures++; $display("FAIL dir%0d_result %h/%h got q=%h r=%h e=%b want q=%h r=%h e=%b",
                             i, va[i], vb[i], q, r, e, eq, er, ee);
      end
      checks++;
      if (ok && lat != elat) begin
        failures++; $display("FAIL dir%0d_latency got=%0d want=%0d", i, lat, elat);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] q0, r0;
    logic       e0;
    int         lat, bad_stable, bad_ready;
    bit         ok;
    send(16'h1234, 8'h56, 7'h7F, ok);
    if (ok) wait_out(lat, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL bp_timeout no result"); return; end
    q0 = quo_o; r0 = rem_o; e0 = err_o;
    checks++;
    if (q0 !== 8'h36 || r0 !== 8'h10 || e0 !== 1'b0) begin
      failures++; $display("FAIL bp_result got q=%h r=%h e=%b want q=36 r=10 e=0", q0, r0, e0);
    end
    in_valid = 1'b1; dat_in_a = 16'h00FF; dat_in_b = 8'h01;
    bad_stable = 0; bad_ready = 0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      if (out_valid !== 1'b1 || quo_o !== q0 || rem_o !== r0 || err_o !== e0) bad_stable++;
      if (in_ready !== 1'b0) bad_ready++;
    end
    checks++; if (bad_stable != 0) begin failures++; $display("FAIL bp_stable changed_cycles got=%0d want=0", bad_stable); end
    checks++; if (bad_ready != 0) begin failures++; $display("FAIL bp_in_ready high_cycles got=%0d want=0", bad_ready); end
    in_valid = 1'b0;
    consume();
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_return got=%b want=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_valid_clear got=%b want=0", out_valid); end
  endtask

  task automatic test_mask();
    logic [7:0] q, r, want_q;
    logic       e;
    int         lat;
    bit         ok;
`ifdef ERCD16_8_MASK_EN
    want_q = 8'h06;
`else
    want_q = 8'h36;
`endif
    run_one(16'h1234, 8'h56, 7'h0F, q, r, e, lat, ok);
    checks++;
    if (!ok || q !== want_q || r !== 8'h10 || e !== 1'b0) begin
      failures++; $display("FAIL mask_result ok=%b got q=%h r=%h e=%b want q=%h r=10 e=0", ok, q, r, e, want_q);
    end
  endtask

  task automatic test_reset_mid();
    bit         ok;
    int         seen;
    logic [7:0] q, r;
    logic       e;
    int         lat;
    send(16'h1234, 8'h56, 7'h7F, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL rmid_accept not accepted"); return; end
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || quo_o !== 8'h00 || rem_o !== 8'h00 || err_o !== 1'b0) begin
      failures++; $display("FAIL rmid_outputs got v=%b rdy=%b q=%h r=%h e=%b want v=0 rdy=1 q=00 r=00 e=0",
                           out_valid, in_ready, quo_o, rem_o, err_o);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    checks++; if (seen != 0) begin failures++; $display("FAIL rmid_no_result valid_cycles got=%0d want=0", seen); end
    run_one(16'h1234, 8'h56, 7'h7F, q, r, e, lat, ok);
    checks++;
    if (!ok || q !== 8'h36 || r !== 8'h10 || e !== 1'b0 || lat != 8) begin
      failures++; $display("FAIL rmid_next ok=%b got q=%h r=%h e=%b lat=%0d want q=36 r=10 e=0 lat=8", ok, q, r, e, lat);
    end
  endtask

  task automatic test_random();
    logic [15:0] a;
    logic [7:0]  b, q, r, eq, er;
    logic [6:0]  m;
    logic        e, ee;
    int          lat, bad;
    bit          ok;
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      b = 8'($urandom_range(0, 255));
      a = 16'($urandom);
      // Bias most requests into the non-overflow range.
      if (b != 0 && $urandom_range(0, 3) != 0)
        a = {8'($urandom_range(0, int'(b) - 1)), 8'($urandom)};
      m = 7'($urandom);
      model(a, b, m, eq, er, ee);
      run_one(a, b, m, q, r, e, lat, ok);
      checks++;
      if (!ok || q !== eq || r !== er || e !== ee || lat != (ee ? 1 : 8)) begin
        failures++; bad++;
        if (bad <= 5)
          $display("FAIL rand%0d %h/%h m=%h ok=%b got q=%h r=%h e=%b lat=%0d want q=%h r=%h e=%b",
                   i, a, b, m, ok, q, r, e, lat, eq, er, ee);
      end
    end
  endtask

  // Continuous requests with out_ready held high measure the initiation interval.
  task automatic test_back_to_back(input logic [15:0] a, input logic [7:0] b, input int want_ii);
    int acc[$];
    in_valid = 1'b1; dat_in_a = a; dat_in_b = b; mask = 7'h7F;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 32; cyc++) begin
      @(negedge clk);
      if (in_ready) acc.push_back(cyc);
    end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (12) @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (acc.size() < 3) begin
      failures++; $display("FAIL b2b_%h_count accepts got=%0d want>=3", b, acc.size());
    end else if (acc[1] - acc[0] != want_ii || acc[2] - acc[1] != want_ii) begin
      failures++; $display("FAIL b2b_%h_ii got=%0d,%0d want=%0d", b, acc[1] - acc[0], acc[2] - acc[1], want_ii);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_mask();
    test_reset_mid();
    test_random();
    test_back_to_back(16'h1234, 8'h56, 10);
    test_back_to_back(16'h00FF, 8'h00, 3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_ercd16_8
